// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: opcodes, arbiter FSM states and defaults.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'b0000,
    ADDI = 4'b0001,
    AND  = 4'b0010,
    OR   = 4'b0011,
    MUL  = 4'b0101,
    DIV  = 4'b0110,
    MULI = 4'b0111,
    DIVI = 4'b1000
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 64;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (alu_op_e'(op))
      ADD, ADDI, AND, OR, MUL, DIV, MULI, DIVI: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] idx_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_rr_arb.sv
// Two-way round-robin grant: the pointed-to requester wins a tie, a lone requester always wins.
module alu_rr_arb
  import alu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req[ptr]) begin
      grant = idx_onehot(ptr);
    end else if (req[~ptr]) begin
      grant = idx_onehot(~ptr);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: round-robin acceptance, one operation in flight,
// timeout on a silent ALU and a response routed back to the owning requester.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0][3:0]     req_opcode,
  input  logic [1:0][N-1:0]   req_a,
  input  logic [1:0][N-1:0]   req_b,
  input  logic [1:0][N-1:0]   req_imm,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [N-1:0]        rsp_data,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic                alu_enable,
  output logic [3:0]          alu_opcode,
  output logic [N-1:0]        alu_dataA,
  output logic [N-1:0]        alu_dataB,
  output logic [N-1:0]        alu_imm,
  input  logic                alu_valid,
  input  logic                alu_zero,
  input  logic [N-1:0]        alu_data
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  arb_state_e    state;
  logic          ptr;
  logic          owner;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    grant;
  logic          sel;
  logic          accept;

  alu_rr_arb u_rr_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Ready is offered only while idle, and never while reset is held.
  assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign sel       = grant[1];
  assign accept    = |req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      alu_enable <= 1'b0;
      alu_opcode <= '0;
      alu_dataA  <= '0;
      alu_dataB  <= '0;
      alu_imm    <= '0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Pointer moves past the winner so the other side gets the next tie.
            owner      <= sel;
            ptr        <= ~sel;
            alu_opcode <= req_opcode[sel];
            alu_dataA  <= req_a[sel];
            alu_dataB  <= req_b[sel];
            alu_imm    <= req_imm[sel];
            wait_cnt   <= '0;
            if (is_legal_op(req_opcode[sel])) begin
              alu_enable <= 1'b1;
              state      <= ISSUE;
            end else begin
              rsp_valid <= idx_onehot(sel);
              rsp_data  <= '0;
              rsp_zero  <= 1'b0;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end
          end
        end

        ISSUE, WAIT: begin
          if (alu_valid) begin
            alu_enable <= 1'b0;
            rsp_valid  <= idx_onehot(owner);
            rsp_data   <= alu_data;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
            state      <= RESP;
          end else if (wait_cnt == LAST_WAIT) begin
            alu_enable <= 1'b0;
            rsp_valid  <= idx_onehot(owner);
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            state    <= WAIT;
          end
        end

        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a Q16.16 stub ALU whose latency is set per test.
module tb_alu_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_opcode;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic [1:0][31:0]  req_imm;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_zero;
  logic              rsp_err;
  logic              alu_enable;
  logic [3:0]        alu_opcode;
  logic [31:0]       alu_dataA;
  logic [31:0]       alu_dataB;
  logic [31:0]       alu_imm;
  logic              alu_valid;
  logic              alu_zero;
  logic [31:0]       alu_data;

  int total = 0;
  int bad   = 0;
  int stub_delay = 0;
  bit stub_never = 0;
  int en_cnt = 0;

  alu_arbiter #(.N(32), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_imm    (req_imm),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_enable (alu_enable),
    .alu_opcode (alu_opcode),
    .alu_dataA  (alu_dataA),
    .alu_dataB  (alu_dataB),
    .alu_imm    (alu_imm),
    .alu_valid  (alu_valid),
    .alu_zero   (alu_zero),
    .alu_data   (alu_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] stubAlu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    logic [63:0] p;
    case (op)
      4'b0000: return a + b;
      4'b0001: return a + imm;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0101: begin p = ({32'b0, a} * {32'b0, b}) >> 16;   return p[31:0]; end
      4'b0111: begin p = ({32'b0, a} * {32'b0, imm}) >> 16; return p[31:0]; end
      4'b0110: begin p = (b != 0) ? ({a, 16'b0} / {32'b0, b}) : 64'd0;   return p[31:0]; end
      4'b1000: begin p = (imm != 0) ? ({a, 16'b0} / {32'b0, imm}) : 64'd0; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  // Stub ALU: raises alu_valid in the (stub_delay+1)-th cycle of alu_enable.
  always @(negedge clk) begin
    if (rst) begin
      en_cnt    = 0;
      alu_valid = 1'b0;
    end else begin
      if (alu_enable && !stub_never && en_cnt == stub_delay) begin
        alu_valid = 1'b1;
        alu_data  = stubAlu(alu_opcode, alu_dataA, alu_dataB, alu_imm);
        alu_zero  = (alu_data == 32'd0);
      end else begin
        alu_valid = 1'b0;
      end
      if (alu_enable) en_cnt++;
      else            en_cnt = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Presents one request and returns at the negedge after it is accepted (the ISSUE cycle).
  task automatic applyStimulus(input string tag, input int idx, input logic [3:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    int n;
    @(negedge clk);
    req_opcode[idx] = op;
    req_a[idx]      = a;
    req_b[idx]      = b;
    req_imm[idx]    = imm;
    req_valid[idx]  = 1'b1;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_ready"}, req_ready, idx_mask(idx));
    @(posedge clk);
    @(negedge clk);
    req_valid[idx] = 1'b0;
  endtask

  function automatic logic [1:0] idx_mask(input int idx);
    return (idx == 1) ? 2'b10 : 2'b01;
  endfunction

  // Called in the cycle after acceptance; measures latency and enable cycles, checks, acknowledges.
  task automatic checkResp(input string tag, input int idx, input logic [31:0] exp_data,
                           input logic exp_zero, input logic exp_err, input int exp_lat,
                           input int exp_en);
    int lat;
    int en;
    lat = 1;
    en  = alu_enable ? 1 : 0;
    while (rsp_valid == 2'b00 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (alu_enable) en++;
    end
    checkOutput({tag, "_valid"}, rsp_valid, idx_mask(idx));
    checkOutput({tag, "_data"},  rsp_data, exp_data);
    checkOutput({tag, "_err"},   rsp_err, exp_err);
    if (!exp_err) checkOutput({tag, "_zero"}, rsp_zero, exp_zero);
    checkOutput({tag, "_lat"},   lat, exp_lat);
    checkOutput({tag, "_en"},    en, exp_en);
    @(negedge clk);
    checkOutput({tag, "_hold_valid"}, rsp_valid, idx_mask(idx));
    checkOutput({tag, "_hold_data"},  rsp_data, exp_data);
    rsp_ready[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[idx] = 1'b0;
    checkOutput({tag, "_drop"}, rsp_valid, 2'b00);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  rr_op   [4];
    logic [31:0] rr_a    [4];
    logic [31:0] rr_b    [4];
    logic [31:0] rr_data [4];
    logic        rr_zero [4];
    int          rr_idx  [4];
    int          idx;
    int          n;

    rr_op   = '{4'b0010, 4'b0011, 4'b0010, 4'b0011};
    rr_a    = '{32'h0000_F0F0, 32'h0000_1200, 32'h0000_00F0, 32'h0000_A000};
    rr_b    = '{32'h0000_0FF0, 32'h0000_0034, 32'h0000_0F00, 32'h0000_000B};
    rr_data = '{32'h0000_00F0, 32'h0000_1234, 32'h0000_0000, 32'h0000_A00B};
    rr_zero = '{1'b0, 1'b0, 1'b1, 1'b0};
    rr_idx  = '{0, 1, 0, 1};

    rst        = 1'b0;
    req_valid  = 2'b00;
    rsp_ready  = 2'b00;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_imm    = '0;
    alu_valid  = 1'b0;
    alu_zero   = 1'b0;
    alu_data   = '0;
    #1 rst = 1'b1;

    // Reset values, with both requesters pushing so ready has a reason to rise.
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("rst_req_ready",  req_ready, 2'b00);
    checkOutput("rst_rsp_valid",  rsp_valid, 2'b00);
    checkOutput("rst_alu_enable", alu_enable, 1'b0);
    checkOutput("rst_rsp_data",   rsp_data, 32'd0);
    checkOutput("rst_flags",      {rsp_zero, rsp_err}, 2'b00);
    checkOutput("rst_alu_ops",    {alu_opcode, alu_dataA, alu_dataB}, 68'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // Both requesters continuously valid: acceptance alternates starting from requester 0.
    req_opcode[0] = rr_op[0]; req_a[0] = rr_a[0]; req_b[0] = rr_b[0];
    req_opcode[1] = rr_op[1]; req_a[1] = rr_a[1]; req_b[1] = rr_b[1];
    @(negedge clk);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 100) begin
        @(negedge clk);
        #1;
        n++;
      end
      checkOutput($sformatf("rr_onehot%0d", k), $countones(req_ready), 1);
      idx = req_ready[1] ? 1 : 0;
      checkOutput($sformatf("rr_order%0d", k), idx, rr_idx[k]);
      @(posedge clk);
      @(negedge clk);
      if (k + 2 < 4) begin
        req_opcode[idx] = rr_op[k+2];
        req_a[idx]      = rr_a[k+2];
        req_b[idx]      = rr_b[k+2];
      end
      checkResp($sformatf("rr%0d", k), rr_idx[k], rr_data[k], rr_zero[k], 1'b0, 2, 1);
    end
    req_valid = 2'b00;

    // ADD 3+4 from requester 0: response two cycles after acceptance.
    applyStimulus("add", 0, 4'b0000, 32'd3, 32'd4, 32'd0);
    checkOutput("add_issue_enable", alu_enable, 1'b1);
    checkOutput("add_issue_opcode", alu_opcode, 4'b0000);
    checkResp("add", 0, 32'd7, 1'b0, 1'b0, 2, 1);

    // Illegal opcode: straight to an error response, ALU never enabled.
    applyStimulus("ill", 1, 4'b1111, 32'd9, 32'd9, 32'd0);
    checkResp("ill", 1, 32'd0, 1'b0, 1'b1, 1, 0);

    // Fixed-point MUL 2.0*3.0 with the stub answering 5 cycles after ISSUE.
    stub_delay = 5;
    applyStimulus("mul", 1, 4'b0101, 32'h0002_0000, 32'h0003_0000, 32'd0);
    checkResp("mul", 1, 32'h0006_0000, 1'b0, 1'b0, 7, 6);
    stub_delay = 0;

    // DIV with a silent ALU: 64 counted cycles then an error response.
    stub_never = 1'b1;
    applyStimulus("tmo", 0, 4'b0110, 32'd100, 32'd5, 32'd0);
    checkResp("tmo", 0, 32'd0, 1'b0, 1'b1, 65, 64);
    stub_never = 1'b0;

    // The FSM is back in IDLE and serves a fresh ADDI.
    applyStimulus("addi", 0, 4'b0001, 32'd10, 32'd0, 32'd5);
    checkResp("addi", 0, 32'd15, 1'b0, 1'b0, 2, 1);

    // Reset in the middle of WAIT, in-flight op owned by requester 0.
    stub_never = 1'b1;
    applyStimulus("flight", 0, 4'b0110, 32'd8, 32'd2, 32'd0);
    repeat (4) @(negedge clk);
    checkOutput("flight_wait_enable", alu_enable, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_enable", alu_enable, 1'b0);
    checkOutput("midrst_valid",  rsp_valid, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    stub_never = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_no_stale", rsp_valid, 2'b00);

    // Both request after reset; requester 1 withdraws after losing and never gets a response.
    req_opcode[0] = 4'b0000; req_a[0] = 32'd1; req_b[0] = 32'd1;
    req_opcode[1] = 4'b0000; req_a[1] = 32'd5; req_b[1] = 32'd5;
    req_valid = 2'b11;
    #1;
    checkOutput("post_rst_grant", req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    checkResp("post_rst_add", 0, 32'd2, 1'b0, 1'b0, 2, 1);
    repeat (3) @(negedge clk);
    checkOutput("withdrawn_no_rsp", rsp_valid, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
